// File: rtl/gf22_fll_pkg.sv
// Shared register map, field layout and reset values for the gf22_fll controller.
package gf22_fll_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_CFG1   = 2'd1;
  localparam logic [1:0] ADDR_CFG2   = 2'd2;
  localparam logic [1:0] ADDR_INTEG  = 2'd3;

  localparam int CODE_W   = 10;
  localparam int FRAC_W   = 10;
  localparam int INTEG_W  = CODE_W + FRAC_W;
  localparam int FACTOR_W = 16;
  localparam int CNT_W    = 6;
  localparam int TOL_W    = 12;
  localparam int GAIN_W   = 4;
  localparam int DIV_W    = 4;

  localparam int CFG1_MODE_BIT   = 31;
  localparam int CFG1_LOCKEN_BIT = 30;
  localparam int CFG1_DIV_LSB    = 26;
  localparam int CFG1_CODE_LSB   = 16;
  localparam int CFG1_TGT_LSB    = 0;

  localparam int CFG2_GAIN_LSB     = 0;
  localparam int CFG2_DEASSERT_LSB = 4;
  localparam int CFG2_ASSERT_LSB   = 10;
  localparam int CFG2_TOL_LSB      = 16;

  localparam int INTEG_INT_LSB  = 16;
  localparam int INTEG_FRAC_LSB = 6;

  localparam logic [31:0] CFG1_RST  = 32'hC080_0200;
  localparam logic [31:0] CFG2_RST  = 32'h0008_4107;
  localparam logic [31:0] INTEG_RST = 32'h0080_0000;

  localparam logic [INTEG_W-1:0] INTEG_Q_RST =
    {INTEG_RST[INTEG_INT_LSB +: CODE_W], INTEG_RST[INTEG_FRAC_LSB +: FRAC_W]};

  typedef enum logic {
    LK_UNLOCKED = 1'b0,
    LK_LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/gf22_fll_lock_det.sv
// Lock qualifier: LOCK toggles only after a run of consecutive qualifying cycles.
// state       | meaning
// LK_UNLOCKED | counting consecutive in-tolerance cycles toward assert
// LK_LOCKED   | counting consecutive out-of-tolerance cycles toward de-assert
module gf22_fll_lock_det
  import gf22_fll_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             lock_en,
  input  logic             in_tol,
  input  logic [CNT_W-1:0] assert_cyc,
  input  logic [CNT_W-1:0] deassert_cyc,
  output logic             lock
);

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] thr;
  logic             hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LK_UNLOCKED;
      cnt_q   <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    thr     = (state_q == LK_LOCKED) ? deassert_cyc : assert_cyc;
    if (thr == '0) thr = CNT_W'(1);
    hit     = (state_q == LK_LOCKED) ? !in_tol : in_tol;
    if (!lock_en) begin
      state_d = LK_UNLOCKED;
    end else if (hit) begin
      if (cnt_q == thr - 1'b1) begin
        state_d = (state_q == LK_LOCKED) ? LK_UNLOCKED : LK_LOCKED;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign lock = (state_q == LK_LOCKED);

endmodule

// File: rtl/gf22_fll.sv
// FLL controller: config port, 10.10 integrating loop, lock detect and a
// REFCLK-domain phase-accumulator stand-in for the DCO output.
module gf22_fll
  import gf22_fll_pkg::*;
#(
  parameter int DCO_W         = 10,
  parameter int MULT_PER_CODE = 4
) (
  input  logic        REFCLK,
  input  logic        RSTB,
  input  logic        FLLOE,
  output logic        FLLCLK,
  output logic        LOCK,
  input  logic        CFGREQ,
  input  logic        CFGWEB,
  input  logic [1:0]  CFGAD,
  input  logic [31:0] CFGD,
  output logic        CFGACK,
  output logic [31:0] CFGQ,
  input  logic        PWD,
  input  logic        RET,
  input  logic        TM,
  input  logic        TE,
  input  logic        TD,
  input  logic        JTD,
  output logic        TQ,
  output logic        JTQ
);

  logic [31:0]         cfg1_q, cfg2_q, rdata_q, rdata;
  logic [INTEG_W-1:0]  integ_q, integ_d, integ_sat;
  logic                ack_q, busy_q, tq_q, jtq_q;
  logic                accept, wr, rd, loop_run, in_tol, lock_raw;
  logic [DCO_W-1:0]    dco_code;
  logic [FACTOR_W-1:0] measured, target;
  logic signed [16:0]  err;
  logic [16:0]         err_abs;
  logic signed [28:0]  err_ext, delta, integ_sum;
  logic [GAIN_W-1:0]   gain, shamt;
  logic [DIV_W-1:0]    div_sh;
  logic [23:0]         osc_acc_q, osc_inc;
  logic                unused_bits;

  assign accept   = CFGREQ & ~busy_q & ~RET;
  assign wr       = accept & ~CFGWEB;
  assign rd       = accept & CFGWEB;
  assign loop_run = cfg1_q[CFG1_MODE_BIT] & ~PWD;

  assign dco_code = cfg1_q[CFG1_MODE_BIT] ? DCO_W'(integ_q[INTEG_W-1 -: CODE_W])
                                          : DCO_W'(cfg1_q[CFG1_CODE_LSB +: CODE_W]);
  assign measured = FACTOR_W'(dco_code) * FACTOR_W'(MULT_PER_CODE);
  assign target   = cfg1_q[CFG1_TGT_LSB +: FACTOR_W];
  assign err      = $signed({1'b0, target}) - $signed({1'b0, measured});
  assign err_abs  = err[16] ? 17'(-err) : 17'(err);
  assign in_tol   = err_abs <= {5'b0, cfg2_q[CFG2_TOL_LSB +: TOL_W]};

  // Gain g scales the error by 2^-g in integer codes; anything above 10 saturates.
  assign gain      = cfg2_q[CFG2_GAIN_LSB +: GAIN_W];
  assign shamt     = (gain > 4'd10) ? 4'd0 : 4'd10 - gain;
  assign err_ext   = {{12{err[16]}}, err};
  assign delta     = err_ext <<< shamt;
  assign integ_sum = $signed({9'b0, integ_q}) + delta;

  always_comb begin
    integ_sat = integ_sum[INTEG_W-1:0];
    if (integ_sum[28])            integ_sat = '0;
    else if (|integ_sum[27:20])   integ_sat = '1;
  end

  always_comb begin
    integ_d = integ_q;
    if (wr && CFGAD == ADDR_INTEG)
      integ_d = {CFGD[INTEG_INT_LSB +: CODE_W], CFGD[INTEG_FRAC_LSB +: FRAC_W]};
    else if (wr && CFGAD == ADDR_CFG1)
      integ_d = {CFGD[CFG1_CODE_LSB +: CODE_W], {FRAC_W{1'b0}}};
    else if (loop_run)
      integ_d = integ_sat;
  end

  always_comb begin
    rdata = '0;
    case (CFGAD)
      ADDR_STATUS: rdata = {16'b0, measured};
      ADDR_CFG1:   rdata = cfg1_q;
      ADDR_CFG2:   rdata = cfg2_q;
      ADDR_INTEG:  rdata = {6'b0, integ_q, 6'b0};
      default:     rdata = '0;
    endcase
  end

  assign div_sh  = (cfg1_q[CFG1_DIV_LSB +: DIV_W] > 4'd8) ? 4'd8 : cfg1_q[CFG1_DIV_LSB +: DIV_W];
  assign osc_inc = {8'b0, measured} << (4'd8 - div_sh);

  // RET freezes every register; a request held across RET is taken afterwards.
  always_ff @(posedge REFCLK or negedge RSTB) begin
    if (!RSTB) begin
      cfg1_q    <= CFG1_RST;
      cfg2_q    <= CFG2_RST;
      integ_q   <= INTEG_Q_RST;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      osc_acc_q <= '0;
      tq_q      <= 1'b0;
      jtq_q     <= 1'b0;
    end else if (!RET) begin
      ack_q  <= accept;
      busy_q <= accept | (busy_q & CFGREQ);
      if (rd) rdata_q <= rdata;
      if (wr && CFGAD == ADDR_CFG1) cfg1_q <= CFGD;
      if (wr && CFGAD == ADDR_CFG2) cfg2_q <= CFGD;
      integ_q <= integ_d;
      if (!PWD) osc_acc_q <= osc_acc_q + osc_inc;
      tq_q  <= TD;
      jtq_q <= JTD;
    end
  end

  gf22_fll_lock_det u_lock_det (
    .clk          (REFCLK),
    .rst_n        (RSTB),
    .hold         (PWD | RET),
    .lock_en      (cfg1_q[CFG1_LOCKEN_BIT]),
    .in_tol       (in_tol),
    .assert_cyc   (cfg2_q[CFG2_ASSERT_LSB +: CNT_W]),
    .deassert_cyc (cfg2_q[CFG2_DEASSERT_LSB +: CNT_W]),
    .lock         (lock_raw)
  );

  assign LOCK   = lock_raw & cfg1_q[CFG1_LOCKEN_BIT] & ~PWD;
  assign FLLCLK = TM ? REFCLK : (FLLOE & ~PWD & (|measured) & osc_acc_q[23]);
  assign CFGACK = ack_q;
  assign CFGQ   = rdata_q;
  assign TQ     = tq_q;
  assign JTQ    = jtq_q;

  assign unused_bits = ^{cfg2_q[31:28], TE};

endmodule

// File: tb/tb_gf22_fll.sv
// Directed bench for gf22_fll: register map, handshake, loop convergence,
// saturation, lock timing, RET/PWD/TM behaviour and reset abort.
module tb_gf22_fll;

  logic        REFCLK, RSTB, FLLOE, FLLCLK, LOCK;
  logic        CFGREQ, CFGWEB, CFGACK;
  logic [1:0]  CFGAD;
  logic [31:0] CFGD, CFGQ;
  logic        PWD, RET, TM, TE, TD, JTD, TQ, JTQ;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  gf22_fll #(.DCO_W(10), .MULT_PER_CODE(4)) dut (
    .REFCLK(REFCLK), .RSTB(RSTB), .FLLOE(FLLOE), .FLLCLK(FLLCLK), .LOCK(LOCK),
    .CFGREQ(CFGREQ), .CFGWEB(CFGWEB), .CFGAD(CFGAD), .CFGD(CFGD),
    .CFGACK(CFGACK), .CFGQ(CFGQ), .PWD(PWD), .RET(RET), .TM(TM), .TE(TE),
    .TD(TD), .JTD(JTD), .TQ(TQ), .JTQ(JTQ)
  );

  initial REFCLK = 1'b0;
  always #5 REFCLK = ~REFCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, CFGQ, e);
  endtask

  task automatic xfer(input logic web, input logic [1:0] ad, input logic [31:0] d,
                      input logic sb, output logic [31:0] q);
    int n;
    @(negedge REFCLK);
    CFGREQ = 1'b1; CFGWEB = web; CFGAD = ad; CFGD = d;
    n = 0;
    do begin @(negedge REFCLK); n++; end while (!CFGACK && n < 20);
    check("ack", {31'b0, CFGACK}, 32'd1);
    q = CFGQ;
    if (web && sb) begin
      if (CFGACK) pop_check();
      else begin exp_q.delete(); tag_q.delete(); end
    end
    CFGREQ = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] ad, input logic [31:0] exp, input string tag);
    logic [31:0] q;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    xfer(1'b1, ad, 32'h0, 1'b1, q);
  endtask

  task automatic cfg_write(input logic [1:0] ad, input logic [31:0] d);
    logic [31:0] q;
    xfer(1'b0, ad, d, 1'b0, q);
  endtask

  initial begin
    int n, acks, highs;
    logic [31:0] q;
    RSTB = 1'b0; FLLOE = 1'b1; CFGREQ = 1'b0; CFGWEB = 1'b1; CFGAD = 2'd0; CFGD = '0;
    PWD = 1'b0; RET = 1'b0; TM = 1'b0; TE = 1'b0; TD = 1'b1; JTD = 1'b1;

    repeat (3) @(negedge REFCLK);
    check("rst_lock", {31'b0, LOCK}, 32'd0);
    check("rst_ack", {31'b0, CFGACK}, 32'd0);
    check("rst_cfgq", CFGQ, 32'h0);
    check("rst_tq", {31'b0, TQ}, 32'd0);
    check("rst_jtq", {31'b0, JTQ}, 32'd0);
    RSTB = 1'b1;

    repeat (15) @(negedge REFCLK);
    check("lock_at_15", {31'b0, LOCK}, 32'd0);
    check("tq_follow", {31'b0, TQ}, 32'd1);
    check("jtq_follow", {31'b0, JTQ}, 32'd1);
    @(negedge REFCLK);
    check("lock_at_16", {31'b0, LOCK}, 32'd1);

    cfg_read(2'd1, 32'hC080_0200, "rd_cfg1_rst");
    cfg_read(2'd2, 32'h0008_4107, "rd_cfg2_rst");
    cfg_read(2'd3, 32'h0080_0000, "rd_integ_rst");
    cfg_read(2'd0, 32'h0000_0200, "rd_status_rst");
    cfg_write(2'd0, 32'hFFFF_FFFF);
    cfg_read(2'd0, 32'h0000_0200, "status_wr_ignored");

    cfg_write(2'd1, 32'hC080_0400);
    n = 0;
    while (LOCK && n < 17) begin @(negedge REFCLK); n++; end
    check("lock_fall", {31'b0, LOCK}, 32'd0);
    n = 0;
    while (!LOCK && n < 400) begin @(negedge REFCLK); n++; end
    check("relock", {31'b0, LOCK}, 32'd1);
    xfer(1'b1, 2'd0, 32'h0, 1'b0, q);
    check("status_converged", {31'b0, (q >= 32'h3F8 && q <= 32'h408)}, 32'd1);

    cfg_write(2'd1, 32'h0123_0000);
    cfg_read(2'd0, 32'h0000_048C, "status_open_loop");
    cfg_read(2'd3, 32'h0123_0000, "integ_open_loop");
    check("lock_disabled", {31'b0, LOCK}, 32'd0);

    @(negedge REFCLK);
    exp_q.push_back(32'h0123_0000); tag_q.push_back("hold_read");
    CFGREQ = 1'b1; CFGWEB = 1'b1; CFGAD = 2'd1;
    acks = 0;
    repeat (10) begin
      @(negedge REFCLK);
      if (CFGACK) begin acks++; if (exp_q.size() > 0) pop_check(); end
    end
    check("hold_acks", acks, 32'd1);
    if (acks == 0) begin exp_q.delete(); tag_q.delete(); end
    CFGREQ = 1'b0;

    @(negedge REFCLK);
    @(negedge REFCLK);
    exp_q.push_back(32'h0008_4107); tag_q.push_back("ret_read");
    RET = 1'b1; CFGREQ = 1'b1; CFGWEB = 1'b1; CFGAD = 2'd2;
    acks = 0;
    repeat (5) begin @(negedge REFCLK); if (CFGACK) acks++; end
    check("ret_no_ack", acks, 32'd0);
    RET = 1'b0;
    @(negedge REFCLK);
    check("ret_ack_after", {31'b0, CFGACK}, 32'd1);
    if (CFGACK) pop_check(); else begin exp_q.delete(); tag_q.delete(); end
    CFGREQ = 1'b0;

    cfg_write(2'd1, 32'h8000_FFFF);
    cfg_write(2'd3, 32'h03FF_FFC0);
    repeat (3) @(negedge REFCLK);
    cfg_read(2'd0, 32'h0000_0FFC, "status_sat_hi");
    cfg_read(2'd3, 32'h03FF_FFC0, "integ_sat_hi");

    cfg_write(2'd2, 32'h0008_4100);
    cfg_write(2'd1, 32'h8080_0000);
    cfg_read(2'd0, 32'h0000_0000, "status_sat_lo");
    cfg_read(2'd3, 32'h0000_0000, "integ_sat_lo");
    highs = 0;
    repeat (8) begin
      @(posedge REFCLK); #1; if (FLLCLK) highs++;
      @(negedge REFCLK); if (FLLCLK) highs++;
    end
    check("fllclk_zero_meas", highs, 32'd0);
    TM = 1'b1;
    @(posedge REFCLK); #1;
    check("tm_clk_high", {31'b0, FLLCLK}, 32'd1);
    @(negedge REFCLK);
    check("tm_clk_low", {31'b0, FLLCLK}, 32'd0);
    TM = 1'b0;

    cfg_write(2'd1, 32'hC080_0200);
    repeat (20) @(negedge REFCLK);
    check("lock_gain0", {31'b0, LOCK}, 32'd1);
    PWD = 1'b1;
    @(negedge REFCLK);
    check("pwd_lock_low", {31'b0, LOCK}, 32'd0);
    check("pwd_clk_low", {31'b0, FLLCLK}, 32'd0);
    cfg_read(2'd2, 32'h0008_4100, "pwd_cfg_read");
    PWD = 1'b0;
    @(negedge REFCLK);
    check("pwd_release_lock", {31'b0, LOCK}, 32'd1);

    @(negedge REFCLK);
    CFGREQ = 1'b1; CFGWEB = 1'b0; CFGAD = 2'd2; CFGD = 32'hFFFF_FFFF;
    #2 RSTB = 1'b0;
    @(negedge REFCLK);
    check("abort_no_ack", {31'b0, CFGACK}, 32'd0);
    CFGREQ = 1'b0;
    @(negedge REFCLK);
    RSTB = 1'b1;
    cfg_read(2'd2, 32'h0008_4107, "abort_no_write");

    FLLOE = 1'b0;
    highs = 0;
    repeat (140) begin @(negedge REFCLK); if (FLLCLK) highs++; end
    check("flloe_off", highs, 32'd0);
    FLLOE = 1'b1;
    highs = 0;
    repeat (140) begin @(negedge REFCLK); if (FLLCLK) highs++; end
    check("fllclk_runs", {31'b0, (highs > 0 && highs < 140)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
